sap_prog_loader: RTL and testbench

- Byte-stream program loader: the writer side of the RAM programming interface (prog_mode / ram_din) of the SAP-1 computer.
- Accepts a framed byte stream over a valid/ready handshake and holds the computer in programming mode.
- Writes each payload byte to sequential RAM addresses 0..DEPTH-1, then verifies an XOR checksum and releases prog_mode.
- Sits between a host link (UART receiver or test stimulus) and the RAM programming inputs.

---
 rtl/sap_pkg.sv | 16 +
 rtl/sap_prog_loader.sv | 125 ++++++++++++
 tb/tb_sap_prog_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: bus widths, program-frame sync byte and loader states.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;
  localparam logic [7:0] SAP_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_LOAD,
    LD_CHECK,
    LD_FIN
  } load_state_t;

endpackage

// File: rtl/sap_prog_loader.sv
// Program loader: takes a framed byte stream (sync, DEPTH payload bytes,
// XOR checksum), writes the payload into the SAP-1 RAM through the
// programming port and holds prog_mode for the duration of the session.
module sap_prog_loader
  import sap_pkg::*;
#(
  parameter int                ADDR_W    = SAP_ADDR_W,
  parameter int                DATA_W    = SAP_DATA_W,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] SYNC_BYTE = SAP_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              prog_mode,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              prog_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Address of the final payload byte; its accept closes the LOAD phase.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_t       state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              accept;

  // Ready depends on state only, so the host may present data freely.
  assign s_ready = (state_reg == LD_HDR) || (state_reg == LD_LOAD) ||
                   (state_reg == LD_CHECK);
  assign accept  = s_valid && s_ready;

  // Session FSM with address counter, checksum accumulator and a one-stage
  // write pipeline; every output is registered here.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= LD_IDLE;
      addr_reg  <= '0;
      acc_reg   <= '0;
      prog_mode <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobes default low; a write accepted last cycle has already issued.
      prog_we <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        LD_IDLE: begin
          // abort in the same cycle as start keeps the loader idle
          if (start && !abort) begin
            state_reg <= LD_HDR;
            prog_mode <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            addr_reg  <= '0;
            acc_reg   <= '0;
          end
        end
        LD_HDR: begin
          if (abort) begin
            state_reg <= LD_IDLE;
            prog_mode <= 1'b0;
            busy      <= 1'b0;
          end else if (accept && (s_data == SYNC_BYTE)) begin
            state_reg <= LD_LOAD;
          end
        end
        LD_LOAD: begin
          if (abort) begin
            state_reg <= LD_IDLE;
            prog_mode <= 1'b0;
            busy      <= 1'b0;
          end else if (accept) begin
            prog_addr <= addr_reg;
            prog_data <= s_data;
            prog_we   <= 1'b1;
            acc_reg   <= acc_reg ^ s_data;
            addr_reg  <= addr_reg + 1'b1;
            if (addr_reg == LAST_ADDR) begin
              state_reg <= LD_CHECK;
            end
          end
        end
        LD_CHECK: begin
          if (abort) begin
            state_reg <= LD_IDLE;
            prog_mode <= 1'b0;
            busy      <= 1'b0;
          end else if (accept) begin
            state_reg <= LD_FIN;
            if (s_data == acc_reg) begin
              err  <= 1'b0;
              done <= 1'b1;
            end else begin
              err  <= 1'b1;
            end
          end
        end
        LD_FIN: begin
          state_reg <= LD_IDLE;
          prog_mode <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= LD_IDLE;
          prog_mode <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Directed bench for the SAP-1 program loader.
module tb_sap_prog_loader;

  logic       clk;
  logic       clr;
  logic       start;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       prog_mode;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_we;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec;
  int n_err;

  logic [3:0] wr_addr[$];
  logic [7:0] wr_data[$];

  sap_prog_loader dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .prog_mode (prog_mode),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write strobe mid-cycle.
  always @(negedge clk) begin
    if (prog_we) begin
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_mode", prog_mode, 1);
    chk("start_err_clr", err, 0);
  endtask

  // Present each byte for one cycle; in gapped mode a dead cycle follows.
  task automatic send_bytes(input logic [7:0] bytes[$], input bit gapped);
    foreach (bytes[i]) begin
      if (!s_ready) begin
        chk("s_ready_hi", s_ready, 1);
      end
      s_valid = 1'b1;
      s_data  = bytes[i];
      tick();
      s_valid = 1'b0;
      if (gapped && i != bytes.size() - 1) begin
        tick();
      end
    end
  endtask

  task automatic check_writes(input string tag, input logic [7:0] exp_data[$]);
    chk({tag, "_wr_cnt"}, wr_addr.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
    end
  endtask

  // Called just after the checksum accept edge (FIN cycle).
  task automatic check_fin(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_mode_fin"}, prog_mode, 1);
    tick();
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_mode_rel"}, prog_mode, 0);
    chk({tag, "_busy_rel"}, busy, 0);
    chk({tag, "_rdy_rel"}, s_ready, 0);
    chk({tag, "_err_hold"}, err, exp_err);
  endtask

  logic [7:0] frame[$];
  logic [7:0] payload[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clr     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", prog_mode, 0);
    chk("rst_we", prog_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_data", prog_data, 0);
    clr = 1'b0;
    tick();

    // Nominal: A5, 00..0F, checksum 00.
    payload = {};
    for (int i = 0; i < 16; i++) payload.push_back(8'(i));
    frame = {8'hA5};
    foreach (payload[i]) frame.push_back(payload[i]);
    frame.push_back(8'h00);
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b0);
    chk("nom_last_wr_before_fin", wr_addr.size(), 16);
    check_fin("nom", 1'b1, 1'b0);
    check_writes("nom", payload);

    // Bad checksum: same frame, checksum 5A.
    frame[17] = 8'h5A;
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b0);
    check_fin("bad", 1'b0, 1'b1);
    check_writes("bad", payload);
    repeat (3) tick();
    chk("bad_err_sticky", err, 1);

    // Resync: 00, FF discarded before A5; payload of 11s, checksum 00.
    payload = {};
    for (int i = 0; i < 16; i++) payload.push_back(8'h11);
    frame = {8'h00, 8'hFF, 8'hA5};
    foreach (payload[i]) frame.push_back(payload[i]);
    frame.push_back(8'h00);
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b0);
    check_fin("resync", 1'b1, 1'b0);
    check_writes("resync", payload);

    // Gapped stream: payload i^3C (checksum 00), valid every other cycle.
    payload = {};
    for (int i = 0; i < 16; i++) payload.push_back(8'(i) ^ 8'h3C);
    frame = {8'hA5};
    foreach (payload[i]) frame.push_back(payload[i]);
    frame.push_back(8'h00);
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b1);
    check_fin("gap", 1'b1, 1'b0);
    check_writes("gap", payload);

    // Abort after 5 payload bytes; the 5th write is still pending.
    payload = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    frame = {8'hA5};
    foreach (payload[i]) frame.push_back(payload[i]);
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_mode", prog_mode, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", s_ready, 0);
    chk("abort_done", done, 0);
    repeat (2) tick();
    check_writes("abort", payload);

    // Restart after abort begins again at address 0.
    payload = {};
    for (int i = 0; i < 16; i++) payload.push_back(8'(i));
    frame = {8'hA5};
    foreach (payload[i]) frame.push_back(payload[i]);
    frame.push_back(8'h00);
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b0);
    check_fin("restart", 1'b1, 1'b0);
    check_writes("restart", payload);

    // abort and start together in IDLE: stays idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abst_busy", busy, 0);
    chk("abst_mode", prog_mode, 0);
    chk("abst_rdy", s_ready, 0);

    // Asynchronous clear mid-LOAD, between clock edges.
    frame = {8'hA5, 8'h01, 8'h02, 8'h03};
    wr_addr.delete(); wr_data.delete();
    do_start();
    send_bytes(frame, 1'b0);
    chk("clr_we_pending", prog_we, 1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_mode", prog_mode, 0);
    chk("clr_we", prog_we, 0);
    chk("clr_busy", busy, 0);
    chk("clr_rdy", s_ready, 0);
    wr_addr.delete(); wr_data.delete();
    tick();
    clr = 1'b0;
    repeat (3) tick();
    chk("clr_no_wr", wr_addr.size(), 0);
    chk("clr_idle_rdy", s_ready, 0);
    chk("clr_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
